bus_interconnect: RTL and testbench



---
 rtl/bus_interconnect.sv | 199 +++++++++++++++++++
 tb/tb_bus_interconnect.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : bus_interconnect
//  Brief    : Single-cycle req/gnt/rvalid interconnect. Fixed-priority host
//             arbitration, runtime base/mask address decode, and one-cycle
//             response routing back to the originating host.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_interconnect #(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  // Host side
  input  logic                      host_req_i     [NrHosts],
  output logic                      host_gnt_o     [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
  input  logic                      host_we_i      [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
  output logic                      host_rvalid_o  [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],
  output logic                      host_err_o     [NrHosts],

  // Device side
  output logic                      device_req_o   [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
  output logic                      device_we_o    [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic                      device_rvalid_i[NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic                      device_err_i   [NrDevices],

  // Address map
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HOST_IDX_W = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int unsigned DEV_IDX_W  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned BE_W       = DataWidth / 8;

  // Arbitration result and the winning host's request fields
  logic                    win_any;
  logic [HOST_IDX_W-1:0]   win_idx;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BE_W-1:0]         win_be;
  logic [DataWidth-1:0]    win_wdata;

  // Decode result for the winning address
  logic                    dev_hit;
  logic [DEV_IDX_W-1:0]    dev_idx;

  // Response routing state
  logic [HOST_IDX_W-1:0]   host_sel_d, host_sel_q;
  logic [DEV_IDX_W-1:0]    dev_sel_d,  dev_sel_q;
  logic                    dec_err_d,  dec_err_q;
  logic                    pending_d,  pending_q;

  // Response of the selected device, before host demux
  logic                    rsp_valid;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_err;

  // Fixed priority: scan downward so the lowest-indexed requester is the last write
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        win_any = 1'b1;
        win_idx = HOST_IDX_W'(h);
      end
    end
  end

  // Mux the winning host's request fields; zero when nobody is requesting
  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (win_any && (win_idx == HOST_IDX_W'(h))) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  // Address decode; downward scan makes the lowest-indexed match win on overlap
  always_comb begin
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dev_hit = 1'b1;
        dev_idx = DEV_IDX_W'(d);
      end
    end
  end

  // Grant the winner regardless of whether its address maps to a device
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h] = win_any && (win_idx == HOST_IDX_W'(h));
    end
  end

  // Forward the request to the single selected device; others see all zeros
  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = '0;
      device_we_o[d]    = 1'b0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
      if (win_any && dev_hit && (dev_idx == DEV_IDX_W'(d))) begin
        device_req_o[d]   = 1'b1;
        device_addr_o[d]  = win_addr;
        device_we_o[d]    = win_we;
        device_be_o[d]    = win_be;
        device_wdata_o[d] = win_wdata;
      end
    end
  end

  // Capture routing on each grant; routing holds otherwise, pending lasts one cycle
  always_comb begin
    host_sel_d = host_sel_q;
    dev_sel_d  = dev_sel_q;
    dec_err_d  = dec_err_q;
    pending_d  = 1'b0;
    if (win_any) begin
      host_sel_d = win_idx;
      dev_sel_d  = dev_hit ? dev_idx : '0;
      dec_err_d  = ~dev_hit;
      pending_d  = 1'b1;
    end
  end

  // Routing state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      host_sel_q <= '0;
      dev_sel_q  <= '0;
      dec_err_q  <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      host_sel_q <= host_sel_d;
      dev_sel_q  <= dev_sel_d;
      dec_err_q  <= dec_err_d;
      pending_q  <= pending_d;
    end
  end

  // Pick the response of the device that was granted last cycle
  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    for (int d = 0; d < NrDevices; d++) begin
      if (dev_sel_q == DEV_IDX_W'(d)) begin
        rsp_valid = device_rvalid_i[d];
        rsp_rdata = device_rdata_i[d];
        rsp_err   = device_err_i[d];
      end
    end
  end

  // Deliver the response only to the originating host; decode errors are synthesised here
  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      host_rvalid_o[h] = 1'b0;
      host_rdata_o[h]  = '0;
      host_err_o[h]    = 1'b0;
      if (pending_q && (host_sel_q == HOST_IDX_W'(h))) begin
        if (dec_err_q) begin
          host_rvalid_o[h] = 1'b1;
          host_err_o[h]    = 1'b1;
        end else begin
          host_rvalid_o[h] = rsp_valid;
          host_rdata_o[h]  = rsp_rdata;
          host_err_o[h]    = rsp_err;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_interconnect
//  Brief    : Scoreboard bench for bus_interconnect with 2 hosts, 3 devices
//             (Ram, SimCtrl, Timer).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

  localparam int NH = 2;
  localparam int ND = 3;

  logic        clk;
  logic        rst_ni;

  logic        host_req_i     [NH];
  logic        host_gnt_o     [NH];
  logic [31:0] host_addr_i    [NH];
  logic        host_we_i      [NH];
  logic [3:0]  host_be_i      [NH];
  logic [31:0] host_wdata_i   [NH];
  logic        host_rvalid_o  [NH];
  logic [31:0] host_rdata_o   [NH];
  logic        host_err_o     [NH];

  logic        device_req_o   [ND];
  logic [31:0] device_addr_o  [ND];
  logic        device_we_o    [ND];
  logic [3:0]  device_be_o    [ND];
  logic [31:0] device_wdata_o [ND];
  logic        device_rvalid_i[ND];
  logic [31:0] device_rdata_i [ND];
  logic        device_err_i   [ND];

  logic [31:0] cfg_base [ND];
  logic [31:0] cfg_mask [ND];

  bus_interconnect #(
    .NrDevices   (ND),
    .NrHosts     (NH),
    .DataWidth   (32),
    .AddressWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .host_req_i          (host_req_i),
    .host_gnt_o          (host_gnt_o),
    .host_addr_i         (host_addr_i),
    .host_we_i           (host_we_i),
    .host_be_i           (host_be_i),
    .host_wdata_i        (host_wdata_i),
    .host_rvalid_o       (host_rvalid_o),
    .host_rdata_o        (host_rdata_o),
    .host_err_o          (host_err_o),
    .device_req_o        (device_req_o),
    .device_addr_o       (device_addr_o),
    .device_we_o         (device_we_o),
    .device_be_o         (device_be_o),
    .device_wdata_o      (device_wdata_o),
    .device_rvalid_i     (device_rvalid_i),
    .device_rdata_i      (device_rdata_i),
    .device_err_i        (device_err_i),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad   = 0;

  // Device response to drive in the next cycle (-1: none)
  int          pend_dev = -1;
  logic [31:0] pend_rsp = '0;
  logic        pend_err = 1'b0;
  logic        rst_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode: lowest-indexed matching device, -1 when unmapped
  function automatic int decode(input logic [31:0] a);
    for (int d = 0; d < ND; d++) begin
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    end
    return -1;
  endfunction

  // One bus cycle: drive device responses for last grant, drive hosts, check, advance
  task automatic step(input logic r0, input logic [31:0] a0,
                      input logic r1, input logic [31:0] a1,
                      input logic we, input logic [31:0] wd,
                      input logic [31:0] rsp, input logic rerr);
    exp_t        e;
    int          exp_h;
    int          w;
    int          dev;
    logic [31:0] wa;
    logic        wwe;
    logic [3:0]  wbe;
    logic [31:0] wwd;
    logic        sel;

    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = (d == pend_dev);
      device_rdata_i[d]  = (d == pend_dev) ? pend_rsp : (32'hBAD0_0000 | d);
      device_err_i[d]    = (d == pend_dev) ? pend_err : 1'b1;
    end

    host_req_i[0] = r0; host_addr_i[0] = a0; host_we_i[0] = we;
    host_be_i[0]  = 4'hF; host_wdata_i[0] = wd;
    host_req_i[1] = r1; host_addr_i[1] = a1; host_we_i[1] = ~we;
    host_be_i[1]  = 4'h3; host_wdata_i[1] = ~wd;
    #2;

    exp_h = -1;
    e = '{host: -1, rdata: 32'h0, err: 1'b0};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_h = e.host;
    end
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("rvalid%0d", h), {31'b0, host_rvalid_o[h]}, {31'b0, (h == exp_h)});
      chk($sformatf("rdata%0d", h),  host_rdata_o[h], (h == exp_h) ? e.rdata : 32'h0);
      chk($sformatf("err%0d", h),    {31'b0, host_err_o[h]}, {31'b0, (h == exp_h) && e.err});
    end

    w   = r0 ? 0 : (r1 ? 1 : -1);
    wa  = (w == 0) ? a0 : a1;
    wwe = (w == 0) ? we : ~we;
    wbe = (w == 0) ? 4'hF : 4'h3;
    wwd = (w == 0) ? wd : ~wd;
    dev = (w >= 0) ? decode(wa) : -1;

    for (int h = 0; h < NH; h++)
      chk($sformatf("gnt%0d", h), {31'b0, host_gnt_o[h]}, {31'b0, (h == w)});
    for (int d = 0; d < ND; d++) begin
      sel = (d == dev);
      chk($sformatf("dreq%0d", d),   {31'b0, device_req_o[d]}, {31'b0, sel});
      chk($sformatf("daddr%0d", d),  device_addr_o[d], sel ? wa : 32'h0);
      chk($sformatf("dwe%0d", d),    {31'b0, device_we_o[d]}, {31'b0, sel && wwe});
      chk($sformatf("dbe%0d", d),    {28'b0, device_be_o[d]}, {28'b0, sel ? wbe : 4'h0});
      chk($sformatf("dwdata%0d", d), device_wdata_o[d], sel ? wwd : 32'h0);
    end

    if (w >= 0) sb.push_back('{host: w, rdata: (dev < 0) ? 32'h0 : rsp, err: (dev < 0) ? 1'b1 : rerr});
    pend_dev = dev;
    pend_rsp = rsp;
    pend_err = rerr;

    if (rst_at_edge) begin
      rst_ni = 1'b0;
      sb.delete();
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic        r0, r1;
    logic [31:0] a0, a1;
    clk    = 1'b0;
    rst_ni = 1'b0;
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;
    for (int h = 0; h < NH; h++) begin
      host_req_i[h] = 1'b0; host_addr_i[h] = '0; host_we_i[h] = 1'b0;
      host_be_i[h] = '0; host_wdata_i[h] = '0;
    end
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1'b0; device_rdata_i[d] = '0; device_err_i[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then single-host directed accesses
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step(1, 32'h0010_0010, 0, 32'h0, 0, 32'h0, 32'hDEAD_BEEF, 0);
    step(1, 32'h0002_0000, 0, 32'h0, 1, 32'h41, 32'h0, 0);
    step(1, 32'h0003_0004, 0, 32'h0, 0, 32'h0, 32'h1234_5678, 1);
    step(1, 32'h0004_0000, 0, 32'h0, 0, 32'h0, 32'h5555_5555, 0);
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Two hosts contend: host0 first, then host1
    step(1, 32'h0010_0000, 1, 32'h0002_0000, 0, 32'h0, 32'h1111_1111, 0);
    step(0, 32'h0, 1, 32'h0002_0000, 0, 32'h0, 32'h2222_2222, 0);
    step(0, 32'h0, 1, 32'h0003_0000, 1, 32'h77, 32'h3333_3333, 1);
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Random back-to-back traffic over mapped and unmapped regions
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a;
        case ($urandom_range(0, 4))
          0: a = 32'h0010_0000 | ($urandom & 32'h0000_FFFC);
          1: a = 32'h0002_0000 | ($urandom & 32'h0000_03FC);
          2: a = 32'h0003_0000 | ($urandom & 32'h0000_03FC);
          3: a = 32'h0004_0000;
          default: a = 32'h5000_0000;
        endcase
        if (k == 0) a0 = a; else a1 = a;
      end
      step(r0, a0, r1, a1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    // Reset sampled at the edge after a grant drops the in-flight response
    rst_at_edge = 1'b1;
    step(1, 32'h0010_0020, 0, 32'h0, 0, 32'h0, 32'hCAFE_F00D, 0);
    rst_at_edge = 1'b0;
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
